// File: rtl/vga_timing_pkg.sv
// Shared timing constants, types and helpers for the 640x480@60 VGA raster generator.
// Optional frame counter is enabled with the VGA_FRAME_CNT_EN macro in vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;
  localparam int unsigned SYNC_DLY_DEF = 2;

  localparam int unsigned H_TOTAL_DEF  = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned HS_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned VS_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  // Sync pins idle high (active-low pulses)
  localparam logic SYNC_RST_LVL = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_RST_VAL = '{hs: SYNC_RST_LVL, vs: SYNC_RST_LVL};

  // Inclusive range test on a raster coordinate
  function automatic logic coord_in_range(input logic [COORD_W-1:0] v,
                                          input int unsigned lo,
                                          input int unsigned hi);
    return (v >= COORD_W'(lo)) && (v <= COORD_W'(hi));
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Width/depth-parameterized shift register with synchronous reset to RST_VAL.
// DEPTH of 0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int unsigned      WIDTH   = 2,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Reset loads every stage so no partial pulse survives a flush
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel/line counters, blank, delayed hs/vs, frame tick/strobe.
// Define VGA_FRAME_CNT_EN to add the 16-bit completed-frame counter output frame_cnt.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS    = H_VIS_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_VIS    = V_VIS_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned SYNC_DLY = SYNC_DLY_DEF
) (
  input  logic               vga_clk,
  input  logic               Reset,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               frame_clk,
  output logic               frame_stb
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               blank_q, blank_d;
  logic               hs_raw_q, hs_raw_d;
  logic               vs_raw_q, vs_raw_d;
  logic               fclk_q, fclk_d;
  logic               stb_q, stb_d;
  sync_t              sync_raw;
  sync_t              sync_dly;

  // Next raster position
  always_comb begin
    x_d = x_q + COORD_W'(1);
    y_d = y_q;
    if (x_q == COORD_W'(H_TOTAL - 1)) begin
      x_d = '0;
      if (y_q == COORD_W'(V_TOTAL - 1)) y_d = '0;
      else                              y_d = y_q + COORD_W'(1);
    end
  end

  // Decode from the next position so flags line up with the coordinates they ship with
  always_comb begin
    blank_d  = (x_d < COORD_W'(H_VIS)) && (y_d < COORD_W'(V_VIS));
    hs_raw_d = ~coord_in_range(x_d, HS_START, HS_END);
    vs_raw_d = ~coord_in_range(y_d, VS_START, VS_END);
    fclk_d   = ~vs_raw_d;
    stb_d    = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      blank_q  <= 1'b0;
      hs_raw_q <= SYNC_RST_LVL;
      vs_raw_q <= SYNC_RST_LVL;
      fclk_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      blank_q  <= blank_d;
      hs_raw_q <= hs_raw_d;
      vs_raw_q <= vs_raw_d;
      fclk_q   <= fclk_d;
      stb_q    <= stb_d;
    end
  end

  assign sync_raw = '{hs: hs_raw_q, vs: vs_raw_q};

  // Sync pins lag coordinates by the compositor's ROM + RGB register latency
  sync_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (SYNC_DLY),
    .RST_VAL (SYNC_RST_VAL)
  ) u_sync_dly (
    .clk_i (vga_clk),
    .rst_i (Reset),
    .d_i   (sync_raw),
    .q_o   (sync_dly)
  );

  assign DrawX     = x_q;
  assign DrawY     = y_q;
  assign blank     = blank_q;
  assign hs        = sync_dly.hs;
  assign vs        = sync_dly.vs;
  assign frame_clk = fclk_q;
  assign frame_stb = stb_q;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Counts wraps to (0,0); rolls over naturally at 0xFFFF
  always_ff @(posedge vga_clk) begin
    if (Reset)      frame_cnt_q <= '0;
    else if (stb_d) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-timing instance plus a shrunken-raster instance so whole
// frames fit in a short run; both compared every cycle against a position-arithmetic model.
module tb_vga_timing_gen;

  localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VV = 12, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_D  = 3;

  logic       clk;
  logic       rst;
  logic [9:0] bx, by, sx, sy;
  logic       bbl, bhs, bvs, bfc, bfs;
  logic       sbl, shs, svs, sfc, sfs;
  logic [15:0] bcnt, scnt;

  int n_cmp;
  int n_err;
  int k;
  bit in_rst;

  vga_timing_gen u_dut (
    .vga_clk   (clk),
    .Reset     (rst),
    .DrawX     (bx),
    .DrawY     (by),
    .blank     (bbl),
    .hs        (bhs),
    .vs        (bvs),
    .frame_clk (bfc),
    .frame_stb (bfs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (bcnt)
`endif
  );

  vga_timing_gen #(
    .H_VIS (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_VIS (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .SYNC_DLY (S_D)
  ) u_small (
    .vga_clk   (clk),
    .Reset     (rst),
    .DrawX     (sx),
    .DrawY     (sy),
    .blank     (sbl),
    .hs        (shs),
    .vs        (svs),
    .frame_clk (sfc),
    .frame_stb (sfs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (scnt)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign bcnt = '0;
  assign scnt = '0;
`endif

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, obs, exp_v, k, $time);
    end
  endtask

  // Model: k edges since reset release -> raster position by plain modular arithmetic
  task automatic check_dut(input string pfx,
                           input int hv, input int hf, input int hsn, input int hb,
                           input int vv, input int vf, input int vsn, input int vb,
                           input int d,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic bl, input logic h, input logic v,
                           input logic fc, input logic fs, input logic [15:0] cnt);
    int ht, vt, fl, p, ex, ey, kd, pd, xd, yd;
    bit e_bl, e_hs, e_vs, e_fc, e_fs;
    ht = hv + hf + hsn + hb;
    vt = vv + vf + vsn + vb;
    fl = ht * vt;
    p  = k % fl;
    ex = p % ht;
    ey = p / ht;
    e_bl = !in_rst && (ex < hv) && (ey < vv);
    e_fc = !in_rst && (ey >= vv + vf) && (ey <= vv + vf + vsn - 1);
    e_fs = !in_rst && (k > 0) && (p == 0);
    kd = k - d;
    if (kd <= 0) begin
      e_hs = 1'b1;
      e_vs = 1'b1;
    end else begin
      pd = kd % fl;
      xd = pd % ht;
      yd = pd / ht;
      e_hs = !((xd >= hv + hf) && (xd <= hv + hf + hsn - 1));
      e_vs = !((yd >= vv + vf) && (yd <= vv + vf + vsn - 1));
    end
    check_eq({pfx, ".DrawX"},     32'(x),  32'(ex));
    check_eq({pfx, ".DrawY"},     32'(y),  32'(ey));
    check_eq({pfx, ".blank"},     32'(bl), 32'(e_bl));
    check_eq({pfx, ".hs"},        32'(h),  32'(e_hs));
    check_eq({pfx, ".vs"},        32'(v),  32'(e_vs));
    check_eq({pfx, ".frame_clk"}, 32'(fc), 32'(e_fc));
    check_eq({pfx, ".frame_stb"}, 32'(fs), 32'(e_fs));
`ifdef VGA_FRAME_CNT_EN
    check_eq({pfx, ".frame_cnt"}, 32'(cnt), 32'(16'(k / fl)));
`else
    if (cnt !== 16'h0) check_eq({pfx, ".cnt_tie"}, 32'(cnt), 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    in_rst = rst;
    if (rst) k = 0;
    else     k++;
    @(negedge clk);
    check_dut("big", 640, 16, 96, 48, 480, 10, 2, 33, 2,
              bx, by, bbl, bhs, bvs, bfc, bfs, bcnt);
    check_dut("small", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_D,
              sx, sy, sbl, shs, svs, sfc, sfs, scnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    k = 0;
    in_rst = 1'b1;
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    // Covers three full lines of the default raster and ~3.7 small frames
    repeat (2500) step();
    for (int seg = 0; seg < 12; seg++) begin
      rst = 1'b1;
      repeat ($urandom_range(1, 4)) step();
      rst = 1'b0;
      repeat ($urandom_range(50, 4000)) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
